// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and geometry for the instruction-cache refill path.
// Cache is direct-mapped, 8 lines of 128 bits, 25-bit tag.
package icache_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int LINE_W       = 128;
  localparam int OFFSET_BITS  = 4;
  localparam int INDEX_BITS   = 3;
  localparam int TAG_BITS     = 25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_FILL,
    S_RELOOK
  } state_t;

  function automatic logic [FETCH_ADDR_W-1:0] line_align(input logic [FETCH_ADDR_W-1:0] a);
    return {a[FETCH_ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Memory read handshake plus cache fill port between the refill controller,
// instruction memory and the cache data/tag arrays.
interface icache_refill_ctrl_if;
  import icache_pkg::*;

  logic                    mem_req;
  logic [FETCH_ADDR_W-1:0] mem_addr;
  logic                    mem_ready;
  logic [LINE_W-1:0]       mem_data;
  logic                    fill_valid;
  logic [FETCH_ADDR_W-1:0] fill_addr;
  logic [LINE_W-1:0]       fill_data;

  modport master (
    output mem_req, mem_addr, fill_valid, fill_addr, fill_data,
    input  mem_ready, mem_data
  );

  modport slave (
    input  mem_req, mem_addr, fill_valid, fill_addr, fill_data,
    output mem_ready, mem_data
  );

endinterface

// File: rtl/icache_refill_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Stalls the PC on an I-cache miss, fetches the aligned line from memory,
// fills the cache and releases the stall once the re-lookup hits.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fetch_valid,
  input  logic [FETCH_ADDR_W-1:0] fetch_addr,
  input  logic                    cache_hit,
  output logic                    stall,
  output logic                    instr_valid,
  icache_refill_ctrl_if.master    bus,
  output logic [CNT_W-1:0]        miss_count,
  output logic                    mem_error
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t                  state, state_nxt;
  logic [FETCH_ADDR_W-1:0] addr_q, miss_addr;
  logic                    valid_q;
  logic [LINE_W-1:0]       line_q;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    miss, timeout, req, fill;

  assign miss    = (state == S_CHECK) && valid_q && !cache_hit;
  assign timeout = (state == S_REQ) && !bus.mem_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fetch_valid) state_nxt = S_CHECK;
      S_CHECK: begin
        if (miss)                            state_nxt = S_REQ;
        else if (!valid_q && !fetch_valid)   state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (bus.mem_ready) state_nxt = S_FILL;
        else if (timeout)  state_nxt = S_IDLE;
      end
      S_FILL:   state_nxt = S_RELOOK;
      S_RELOOK: state_nxt = S_CHECK;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    instr_valid = 1'b0;
    req         = 1'b0;
    fill        = 1'b0;
    case (state)
      S_CHECK: begin
        stall       = miss;
        instr_valid = valid_q && cache_hit;
      end
      S_REQ: begin
        stall = 1'b1;
        req   = 1'b1;
      end
      S_FILL: begin
        stall = 1'b1;
        fill  = 1'b1;
      end
      S_RELOOK: stall = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_req    = req;
  assign bus.mem_addr   = req  ? miss_addr : '0;
  assign bus.fill_valid = fill;
  assign bus.fill_addr  = fill ? miss_addr : '0;
  assign bus.fill_data  = fill ? line_q    : '0;

  // addr_q freezes while stalled so the re-lookup targets the missing line
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q    <= '0;
      valid_q   <= 1'b0;
      miss_addr <= '0;
      line_q    <= '0;
      mem_error <= 1'b0;
    end else begin
      if (!stall) begin
        addr_q  <= fetch_addr;
        valid_q <= fetch_valid;
      end
      if (miss)                            miss_addr <= line_align(addr_q);
      if ((state == S_REQ) && bus.mem_ready) line_q  <= bus.mem_data;
      if (timeout)                         mem_error <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (miss),
    .count (miss_count)
  );

  // Held clear outside REQ, so it counts from 0 on the first REQ cycle
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clock (clock),
    .reset (reset || (state != S_REQ)),
    .inc   (state == S_REQ),
    .count (wait_cnt)
  );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed per-cycle vector table for the refill controller (TIMEOUT=8, CNT_W=2),
// followed by a responder-driven refill with bounded waits.
module tb_icache_refill_ctrl;
  import icache_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        cache_hit;
  logic        stall;
  logic        instr_valid;
  logic [1:0]  miss_count;
  logic        mem_error;

  icache_refill_ctrl_if bus();

  icache_refill_ctrl #(.TIMEOUT(8), .CNT_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .cache_hit   (cache_hit),
    .stall       (stall),
    .instr_valid (instr_valid),
    .bus         (bus),
    .miss_count  (miss_count),
    .mem_error   (mem_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst, fv;
    logic [31:0] fa;
    logic        hit, rdy;
    int          d;
    logic        stall, iv, req;
    logic [31:0] maddr;
    logic        fvld;
    logic [31:0] faddr;
    logic [1:0]  mc;
    logic        err;
  } vec_t;

  vec_t         vecs[$];
  logic [127:0] lines [2];
  int           checks = 0;
  int           fails  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic rst, input logic fv, input logic [31:0] fa,
                     input logic hit, input logic rdy, input int d,
                     input logic st, input logic iv, input logic req, input logic [31:0] maddr,
                     input logic fvld, input logic [31:0] faddr, input logic [1:0] mc,
                     input logic err);
    vec_t v;
    v.name = nm; v.rst = rst; v.fv = fv; v.fa = fa; v.hit = hit; v.rdy = rdy; v.d = d;
    v.stall = st; v.iv = iv; v.req = req; v.maddr = maddr; v.fvld = fvld; v.faddr = faddr;
    v.mc = mc; v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    int          req_seen, stall_cnt, fill_seen;
    logic        filled, done;
    logic [127:0] exp_fd;

    lines[0] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    lines[1] = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123_4567;

    //   name             rst fv fa            hit rdy d   st iv rq maddr       fv faddr       mc er
    add("cold_idle",      0, 1, 32'h0,        0, 0, 0,  0, 0, 0, 32'h0,      0, 32'h0,      0, 0);
    add("cold_miss",      0, 1, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,      0, 32'h0,      0, 0);
    add("cold_req1",      0, 1, 32'h0,        0, 0, 0,  1, 0, 1, 32'h0,      0, 32'h0,      1, 0);
    add("cold_req2",      0, 1, 32'h0,        0, 0, 0,  1, 0, 1, 32'h0,      0, 32'h0,      1, 0);
    add("cold_req3",      0, 1, 32'h0,        0, 1, 0,  1, 0, 1, 32'h0,      0, 32'h0,      1, 0);
    add("cold_fill",      0, 1, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,      1, 32'h0,      1, 0);
    add("cold_relook",    0, 1, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,      0, 32'h0,      1, 0);
    add("seq_0",          0, 1, 32'h4,        1, 0, 0,  0, 1, 0, 32'h0,      0, 32'h0,      1, 0);
    add("seq_4",          0, 1, 32'h8,        1, 0, 0,  0, 1, 0, 32'h0,      0, 32'h0,      1, 0);
    add("seq_8",          0, 1, 32'hC,        1, 0, 0,  0, 1, 0, 32'h0,      0, 32'h0,      1, 0);
    add("seq_c",          0, 1, 32'h80,       1, 0, 0,  0, 1, 0, 32'h0,      0, 32'h0,      1, 0);
    add("conf_miss",      0, 1, 32'h12345678, 0, 0, 1,  1, 0, 0, 32'h0,      0, 32'h0,      1, 0);
    add("conf_req",       0, 1, 32'hDEADBEE0, 0, 1, 1,  1, 0, 1, 32'h80,     0, 32'h0,      2, 0);
    add("conf_fill",      0, 1, 32'h0000FFF0, 0, 0, 1,  1, 0, 0, 32'h0,      1, 32'h80,     2, 0);
    add("conf_relook",    0, 1, 32'h40,       0, 0, 1,  1, 0, 0, 32'h0,      0, 32'h0,      2, 0);
    add("conf_hit",       0, 0, 32'h80,       1, 0, 1,  0, 1, 0, 32'h0,      0, 32'h0,      2, 0);
    add("to_chk_idle",    0, 0, 32'h80,       0, 0, 0,  0, 0, 0, 32'h0,      0, 32'h0,      2, 0);
    add("to_idle",        0, 1, 32'h100,      0, 0, 0,  0, 0, 0, 32'h0,      0, 32'h0,      2, 0);
    add("to_miss",        0, 1, 32'h100,      0, 0, 0,  1, 0, 0, 32'h0,      0, 32'h0,      2, 0);
    for (int k = 0; k < 8; k++)
      add($sformatf("to_req%0d", k), 0, 0, 32'h100, 0, 0, 0, 1, 0, 1, 32'h100, 0, 32'h0, 3, 0);
    add("to_err",         0, 0, 32'h0,        0, 1, 0,  0, 0, 0, 32'h0,      0, 32'h0,      3, 1);
    add("to_stray_rdy",   0, 0, 32'h0,        0, 0, 0,  0, 0, 0, 32'h0,      0, 32'h0,      3, 1);
    add("rs_idle",        0, 1, 32'h200,      0, 0, 0,  0, 0, 0, 32'h0,      0, 32'h0,      3, 1);
    add("rs_miss_sat",    0, 1, 32'h200,      0, 0, 0,  1, 0, 0, 32'h0,      0, 32'h0,      3, 1);
    add("rs_req_rst",     1, 1, 32'h200,      0, 0, 0,  1, 0, 1, 32'h200,    0, 32'h0,      3, 1);
    add("rs_after",       0, 0, 32'h200,      0, 1, 0,  0, 0, 0, 32'h0,      0, 32'h0,      0, 0);
    add("rs_nofill",      0, 0, 32'h200,      0, 0, 0,  0, 0, 0, 32'h0,      0, 32'h0,      0, 0);
    add("fd_idle",        0, 1, 32'h300,      0, 0, 0,  0, 0, 0, 32'h0,      0, 32'h0,      0, 0);
    add("fd_miss",        0, 1, 32'h300,      0, 0, 0,  1, 0, 0, 32'h0,      0, 32'h0,      0, 0);
    add("fd_req1",        0, 0, 32'h300,      0, 0, 0,  1, 0, 1, 32'h300,    0, 32'h0,      1, 0);
    add("fd_req2",        0, 0, 32'h300,      0, 1, 0,  1, 0, 1, 32'h300,    0, 32'h0,      1, 0);
    add("fd_fill",        0, 0, 32'h300,      0, 0, 0,  1, 0, 0, 32'h0,      1, 32'h300,    1, 0);
    add("fd_relook",      0, 0, 32'h300,      0, 0, 0,  1, 0, 0, 32'h0,      0, 32'h0,      1, 0);
    add("fd_hit",         0, 0, 32'h300,      1, 0, 0,  0, 1, 0, 32'h0,      0, 32'h0,      1, 0);
    add("fd_chk_idle",    0, 0, 32'h300,      0, 0, 0,  0, 0, 0, 32'h0,      0, 32'h0,      1, 0);
    add("rl_idle",        0, 1, 32'h400,      0, 0, 1,  0, 0, 0, 32'h0,      0, 32'h0,      1, 0);
    add("rl_miss",        0, 1, 32'h400,      0, 0, 1,  1, 0, 0, 32'h0,      0, 32'h0,      1, 0);
    add("rl_req",         0, 1, 32'h400,      0, 1, 1,  1, 0, 1, 32'h400,    0, 32'h0,      2, 0);
    add("rl_fill",        0, 1, 32'h400,      0, 0, 1,  1, 0, 0, 32'h0,      1, 32'h400,    2, 0);
    add("rl_relook",      0, 1, 32'h400,      0, 0, 1,  1, 0, 0, 32'h0,      0, 32'h0,      2, 0);
    add("rl_miss2",       0, 1, 32'h400,      0, 0, 1,  1, 0, 0, 32'h0,      0, 32'h0,      2, 0);
    add("rl_req2",        0, 1, 32'h400,      0, 1, 1,  1, 0, 1, 32'h400,    0, 32'h0,      3, 0);
    add("rl_fill2",       0, 1, 32'h400,      0, 0, 1,  1, 0, 0, 32'h0,      1, 32'h400,    3, 0);
    add("rl_relook2",     0, 1, 32'h400,      0, 0, 1,  1, 0, 0, 32'h0,      0, 32'h0,      3, 0);
    add("rl_hit",         0, 1, 32'h404,      1, 0, 1,  0, 1, 0, 32'h0,      0, 32'h0,      3, 0);
    add("rl_hit404",      0, 0, 32'h404,      1, 0, 1,  0, 1, 0, 32'h0,      0, 32'h0,      3, 0);
    add("rl_chk_idle",    0, 0, 32'h404,      0, 0, 1,  0, 0, 0, 32'h0,      0, 32'h0,      3, 0);

    reset = 1'b1; fetch_valid = 1'b0; fetch_addr = '0; cache_hit = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_data = '0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("rst.stall", stall, 0);
    chk("rst.instr_valid", instr_valid, 0);
    chk("rst.mem_req", bus.mem_req, 0);
    chk("rst.mem_addr", bus.mem_addr, 0);
    chk("rst.fill_valid", bus.fill_valid, 0);
    chk("rst.fill_addr", bus.fill_addr, 0);
    chk("rst.fill_data", bus.fill_data, 0);
    chk("rst.miss_count", miss_count, 0);
    chk("rst.mem_error", mem_error, 0);

    foreach (vecs[i]) begin
      @(posedge clock); #1;
      reset         = vecs[i].rst;
      fetch_valid   = vecs[i].fv;
      fetch_addr    = vecs[i].fa;
      cache_hit     = vecs[i].hit;
      bus.mem_ready = vecs[i].rdy;
      bus.mem_data  = lines[vecs[i].d];
      @(negedge clock);
      exp_fd = vecs[i].fvld ? lines[vecs[i].d] : '0;
      chk({vecs[i].name, ".stall"},       stall,          vecs[i].stall);
      chk({vecs[i].name, ".instr_valid"}, instr_valid,    vecs[i].iv);
      chk({vecs[i].name, ".mem_req"},     bus.mem_req,    vecs[i].req);
      chk({vecs[i].name, ".mem_addr"},    bus.mem_addr,   vecs[i].maddr);
      chk({vecs[i].name, ".fill_valid"},  bus.fill_valid, vecs[i].fvld);
      chk({vecs[i].name, ".fill_addr"},   bus.fill_addr,  vecs[i].faddr);
      chk({vecs[i].name, ".fill_data"},   bus.fill_data,  exp_fd);
      chk({vecs[i].name, ".miss_count"},  miss_count,     vecs[i].mc);
      chk({vecs[i].name, ".mem_error"},   mem_error,      vecs[i].err);
    end

    // Memory responder with L=2; cache reports a hit once the fill has been seen.
    req_seen = 0; stall_cnt = 0; fill_seen = 0; filled = 1'b0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clock); #1;
      reset       = 1'b0;
      fetch_valid = 1'b1;
      fetch_addr  = 32'h508;
      cache_hit   = filled;
      if (bus.mem_req) req_seen++;
      bus.mem_ready = bus.mem_req && (req_seen == 2);
      bus.mem_data  = lines[0];
      @(negedge clock);
      if (stall) stall_cnt++;
      if (bus.fill_valid) begin
        fill_seen++;
        filled = 1'b1;
        chk("hs.fill_addr", bus.fill_addr, 32'h500);
        chk("hs.fill_data", bus.fill_data, lines[0]);
      end
      if (instr_valid && filled) done = 1'b1;
    end
    chk("hs.completed", done, 1);
    chk("hs.stall_cycles", stall_cnt, 5);
    chk("hs.fill_count", fill_seen, 1);
    chk("hs.miss_count_sat", miss_count, 3);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
